// File: rtl/proto_frame_sched_pkg.sv
// Shared definitions for the protocol frame scheduler: channel IDs, FSM
// state encoding and the segment header base.
package proto_frame_sched_pkg;

  localparam logic [1:0] CH_IIC  = 2'd0;
  localparam logic [1:0] CH_SPI  = 2'd1;
  localparam logic [1:0] CH_UART = 2'd2;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_DATA = 3'd4,
    S_CNT  = 3'd5
  } state_t;

  function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [1:0] ch);
    return base | {6'b000000, ch};
  endfunction

endpackage

// File: rtl/proto_frame_sched.sv
// Frame scheduler: drains three channel FIFOs into one byte stream of
// [header, data..., count] segments, in order IIC, SPI, UART.
module proto_frame_sched
  import proto_frame_sched_pkg::*;
#(
  parameter int         P_MAX_BYTES = 15,
  parameter logic [7:0] P_HDR_BASE  = HDR_BASE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_fifo_empty,
  input  logic [23:0] i_fifo_dout,
  output logic [2:0]  o_fifo_rd,
  output logic [7:0]  o_data,
  output logic        o_vld,
  input  logic        i_ready,
  output logic        o_last,
  output logic        o_busy
);

  localparam logic [3:0] LP_MAX = 4'(P_MAX_BYTES);

  // Output handshake: a byte transfers on any rising edge where o_vld and
  // i_ready are both high; o_data/o_vld/o_last are held until then.
  state_t     r_state, w_state_nxt;
  logic [1:0] r_ch,    w_ch_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic [7:0] r_data,  w_data_nxt;
  logic       r_vld,   w_vld_nxt;
  logic       r_last,  w_last_nxt;
  logic       r_busy,  w_busy_nxt;

  logic       w_xfer;
  logic       w_empty_sel;
  logic [7:0] w_dout_sel;
  logic       w_can_rd;

  assign w_xfer      = r_vld & i_ready;
  assign w_empty_sel = i_fifo_empty[r_ch];
  assign w_dout_sel  = i_fifo_dout[{r_ch, 3'b000} +: 8];
  assign w_can_rd    = !w_empty_sel && (r_cnt < LP_MAX);

  // The strobe is combinational on the live empty flag, so it can never
  // fire on a FIFO that is empty in the same cycle.
  assign o_fifo_rd = (r_state == S_RD && w_can_rd) ? (3'b001 << r_ch) : 3'b000;

  assign o_data = r_data;
  assign o_vld  = r_vld;
  assign o_last = r_last;
  assign o_busy = r_busy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ch    <= CH_IIC;
      r_cnt   <= 4'd0;
      r_data  <= 8'h00;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_vld_nxt   = r_vld;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_HDR;
          w_ch_nxt    = CH_IIC;
          w_cnt_nxt   = 4'd0;
          w_data_nxt  = hdr_byte(P_HDR_BASE, CH_IIC);
          w_vld_nxt   = 1'b1;
          w_last_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_HDR, S_DATA: begin
        if (w_xfer) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (w_can_rd) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_data_nxt  = {4'h0, r_cnt};
          w_vld_nxt   = 1'b1;
          w_last_nxt  = (r_ch == CH_UART);
          w_state_nxt = S_CNT;
        end
      end
      S_WAIT: begin
        // FIFO data is valid the cycle after the strobe issued in RD.
        w_data_nxt  = w_dout_sel;
        w_vld_nxt   = 1'b1;
        w_cnt_nxt   = r_cnt + 4'd1;
        w_state_nxt = S_DATA;
      end
      S_CNT: begin
        if (w_xfer) begin
          if (r_ch != CH_UART) begin
            w_ch_nxt    = r_ch + 2'd1;
            w_cnt_nxt   = 4'd0;
            w_data_nxt  = hdr_byte(P_HDR_BASE, r_ch + 2'd1);
            w_vld_nxt   = 1'b1;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_HDR;
          end else begin
            w_vld_nxt   = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_vld_nxt   = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_proto_frame_sched.sv
// Bench for proto_frame_sched: FIFO models feed the DUT, a scoreboard of
// {last, byte} entries is built from FIFO contents at each frame start.
module tb_proto_frame_sched;
  import proto_frame_sched_pkg::*;

  localparam int MAXB = 15;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [2:0]  i_fifo_empty;
  logic [23:0] i_fifo_dout;
  logic [2:0]  o_fifo_rd;
  logic [7:0]  o_data;
  logic        o_vld;
  logic        i_ready;
  logic        o_last;
  logic        o_busy;

  proto_frame_sched #(.P_MAX_BYTES(MAXB), .P_HDR_BASE(8'hA0)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_fifo_empty(i_fifo_empty), .i_fifo_dout(i_fifo_dout),
    .o_fifo_rd(o_fifo_rd), .o_data(o_data), .o_vld(o_vld),
    .i_ready(i_ready), .o_last(o_last), .o_busy(o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  logic [7:0] fifo_q[3][$];
  logic [2:0] rd_pend = 3'b000;
  logic       ready_mode = 1'b0;
  int         rd_count = 0;
  int         busy_cycles = 0;
  logic       frame_done = 1'b0;
  logic       chk_idle = 1'b0;
  logic       held_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO models: a strobe seen in a cycle pops data that is presented just
  // after the following rising edge; ready is re-drawn at the same point.
  always @(posedge clk) begin
    #1;
    if (!i_rst) begin
      for (int n = 0; n < 3; n++)
        if (rd_pend[n] && fifo_q[n].size() > 0)
          i_fifo_dout[8*n +: 8] = fifo_q[n].pop_front();
    end
    rd_pend = 3'b000;
    for (int n = 0; n < 3; n++) i_fifo_empty[n] = (fifo_q[n].size() == 0);
    i_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (i_rst) begin
      held_prev = 1'b0;
      chk_idle  = 1'b0;
    end else begin
      if (chk_idle) begin
        check("busy_clear", {31'd0, o_busy}, 32'd0);
        chk_idle = 1'b0;
      end
      if (o_fifo_rd != 3'b000) begin
        check("rd_onehot", {31'd0, $onehot(o_fifo_rd)}, 32'd1);
        check("rd_on_empty", {29'd0, o_fifo_rd & i_fifo_empty}, 32'd0);
        check("rd_while_held", {31'd0, o_vld}, 32'd0);
        rd_pend = o_fifo_rd;
        rd_count++;
      end
      if (held_prev) begin
        check("hold_vld", {31'd0, o_vld}, 32'd1);
        check("hold_data", {24'd0, o_data}, {24'd0, prev_data});
      end
      if (o_busy) busy_cycles++;
      if (o_vld && i_ready) begin
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("byte", {23'd0, o_last, o_data}, {23'd0, exp_q.pop_front()});
        if (o_last) begin
          frame_done = 1'b1;
          chk_idle   = 1'b1;
        end
      end
      held_prev = o_vld && !i_ready;
      prev_data = o_data;
    end
  end

  // driver tasks
  task automatic build_expected(output int n_reads);
    n_reads = 0;
    for (int c = 0; c < 3; c++) begin
      int n;
      n = (fifo_q[c].size() < MAXB) ? fifo_q[c].size() : MAXB;
      exp_q.push_back({1'b0, 8'hA0 | 8'(c)});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, fifo_q[c][i]});
      exp_q.push_back({c == 2, 8'(n)});
      n_reads += n;
    end
  endtask

  task automatic run_frame(input string tag, input logic extra_starts);
    int n_reads;
    int cyc;
    build_expected(n_reads);
    rd_count    = 0;
    busy_cycles = 0;
    frame_done  = 1'b0;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_busy_set"}, {31'd0, o_busy}, 32'd1);
    cyc = 0;
    while (!frame_done && cyc < 2000) begin
      i_start = extra_starts && (cyc == 4 || cyc == 11 || cyc == 15);
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    check({tag, "_timeout"}, {31'd0, frame_done}, 32'd1);
    if (!ready_mode) check({tag, "_cycles"}, busy_cycles, 9 + 3 * n_reads);
    repeat (10) @(negedge clk);
    check({tag, "_reads"}, rd_count, n_reads);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_idle_after"}, {30'd0, o_busy, o_vld}, 32'd0);
  endtask

  task automatic load_basic();
    for (int c = 0; c < 3; c++) fifo_q[c].delete();
    fifo_q[0].push_back(8'h11);
    fifo_q[0].push_back(8'h22);
    fifo_q[2].push_back(8'h33);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_ready = 1'b1;
    i_fifo_empty = 3'b111;
    i_fifo_dout = 24'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'd0, o_vld, o_last, o_busy, o_fifo_rd != 3'b000}, 32'd0);
    check("reset_data", {24'd0, o_data}, 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic frame: A0 11 22 02 A1 00 A2 33 01
    load_basic();
    run_frame("basic", 1'b0);

    // all empty
    for (int c = 0; c < 3; c++) fifo_q[c].delete();
    @(negedge clk);
    run_frame("empty", 1'b0);

    // overflow cap: 20 bytes on ch1 -> 15 then 5
    for (int i = 0; i < 20; i++) fifo_q[1].push_back(8'($urandom_range(0, 255)));
    @(negedge clk);
    run_frame("ovf1", 1'b0);
    check("ovf_left", fifo_q[1].size(), 5);
    run_frame("ovf2", 1'b0);
    check("ovf_drained", fifo_q[1].size(), 0);

    // backpressure
    ready_mode = 1'b1;
    load_basic();
    run_frame("bp", 1'b0);

    // random frames under backpressure, with ignored starts mid-frame
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 3; c++) begin
        int k;
        k = $urandom_range(0, 18);
        for (int i = 0; i < k; i++) fifo_q[c].push_back(8'($urandom_range(0, 255)));
      end
      @(negedge clk);
      run_frame("rand", 1'b1);
    end
    ready_mode = 1'b0;

    // start while busy
    load_basic();
    run_frame("dup_start", 1'b1);

    // reset during ch1 DATA
    for (int c = 0; c < 3; c++) fifo_q[c].delete();
    fifo_q[0].push_back(8'h01);
    for (int i = 0; i < 4; i++) fifo_q[1].push_back(8'h10 + 8'(i));
    @(negedge clk);
    begin
      int dummy;
      build_expected(dummy);
    end
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (!(dut.r_state == S_DATA && dut.r_ch == CH_SPI) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_data", {31'd0, cyc < 200}, 32'd1);
    #1;
    i_rst = 1'b1;
    #1;
    check("rst_async_ctrl", {27'd0, o_vld, o_last, o_busy, o_fifo_rd != 3'b000}, 32'd0);
    check("rst_async_data", {24'd0, o_data}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    rd_count = 0;
    repeat (5) @(negedge clk);
    check("rst_no_reads", rd_count, 0);
    check("rst_idle", {30'd0, o_busy, o_vld}, 32'd0);
    run_frame("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
